// File: rtl/avalon_master_comando_if.sv
// Command handshake plus Avalon-MM bus bundle for avalon_master_comando.
// The master modport is the controller side; the slave modport is the environment side.
interface avalon_master_comando_if;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        done;
    logic        timeout_err;
    logic        buf_sel;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_data, avm_readdata, avm_waitrequest,
        output cmd_ready, done, timeout_err, buf_sel,
               avm_address, avm_chipselect, avm_write, avm_read, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_data, avm_readdata, avm_waitrequest,
        input  cmd_ready, done, timeout_err, buf_sel,
               avm_address, avm_chipselect, avm_write, avm_read, avm_writedata
    );
endinterface

// File: rtl/avalon_master_comando.sv
// Avalon-MM master: writes a command, polls status until done or timeout.
// Optional macro BUFFER_SWAP_EN adds a buffer-select write (address 2) after each success.
module avalon_master_comando #(
    parameter int POLL_GAP      = 4,
    parameter int TIMEOUT_POLLS = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_master_comando_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_RD_STAT,
        S_GAP,
`ifdef BUFFER_SWAP_EN
        S_WR_BUF,
`endif
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_POLLS);

    state_t            state_q, state_d;
    logic [31:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  poll_inc;
    logic              unused_status_bits;
`ifdef BUFFER_SWAP_EN
    logic              buf_sel_q, buf_sel_d;
`endif

    assign unused_status_bits = ^bus.avm_readdata[31:1];
    assign poll_inc = (poll_cnt_q == {CNT_W{1'b1}}) ? poll_cnt_q : poll_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= '0;
            poll_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`ifdef BUFFER_SWAP_EN
            buf_sel_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            poll_cnt_q    <= poll_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            timeout_err_q <= timeout_err_d;
`ifdef BUFFER_SWAP_EN
            buf_sel_q     <= buf_sel_d;
`endif
        end
    end

    // A bus state only advances once the slave drops waitrequest, which keeps the request stable.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        poll_cnt_d    = poll_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        timeout_err_d = timeout_err_q;
`ifdef BUFFER_SWAP_EN
        buf_sel_d     = buf_sel_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d         = bus.cmd_data;
                    timeout_err_d = 1'b0;
                    poll_cnt_d    = '0;
                    state_d       = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                if (!bus.avm_waitrequest) state_d = S_RD_STAT;
            end
            S_RD_STAT: begin
                if (!bus.avm_waitrequest) begin
                    if (bus.avm_readdata[0]) begin
`ifdef BUFFER_SWAP_EN
                        state_d = S_WR_BUF;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        poll_cnt_d = poll_inc;
                        if ((TIMEOUT_POLLS != 0) && (poll_inc == TIMEOUT_LIM)) begin
                            timeout_err_d = 1'b1;
                            state_d       = S_DONE;
                        end else if (POLL_GAP == 0) begin
                            state_d = S_RD_STAT;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_RD_STAT;
                else gap_cnt_d = gap_cnt_q + CNT_W'(1);
            end
`ifdef BUFFER_SWAP_EN
            S_WR_BUF: begin
                if (!bus.avm_waitrequest) begin
                    buf_sel_d = ~buf_sel_q;
                    state_d   = S_DONE;
                end
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready      = 1'b0;
        bus.done           = 1'b0;
        bus.avm_chipselect = 1'b0;
        bus.avm_write      = 1'b0;
        bus.avm_read       = 1'b0;
        bus.avm_address    = 3'd0;
        bus.avm_writedata  = 32'h0;
        bus.timeout_err    = timeout_err_q;
`ifdef BUFFER_SWAP_EN
        bus.buf_sel        = buf_sel_q;
`else
        bus.buf_sel        = 1'b0;
`endif
        case (state_q)
            S_IDLE: bus.cmd_ready = 1'b1;
            S_WR_CMD: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_write      = 1'b1;
                bus.avm_address    = 3'd0;
                bus.avm_writedata  = cmd_q;
            end
            S_RD_STAT: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_read       = 1'b1;
                bus.avm_address    = 3'd1;
            end
`ifdef BUFFER_SWAP_EN
            S_WR_BUF: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_write      = 1'b1;
                bus.avm_address    = 3'd2;
                bus.avm_writedata  = {31'h0, ~buf_sel_q};
            end
`endif
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_avalon_master_comando.sv
// Self-checking bench for avalon_master_comando: scripted slave, transfer log and
// a transaction-level model of the expected bus sequence per command.
module tb_avalon_master_comando;
    localparam int POLL_GAP      = 4;
    localparam int TIMEOUT_POLLS = 8;
`ifdef BUFFER_SWAP_EN
    localparam int SWAP = 1;
`else
    localparam int SWAP = 0;
`endif

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } xfer_t;

    logic clk;
    logic reset;
    avalon_master_comando_if bus ();

    avalon_master_comando #(
        .POLL_GAP(POLL_GAP),
        .TIMEOUT_POLLS(TIMEOUT_POLLS),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    xfer_t log_q[$];
    int    log_cyc[$];
    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    done_count = 0;
    int    zero_polls = 0;
    int    max_stall = 0;
    int    stall_wr_cmd = 0;
    logic  model_buf = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: answers each new request after a chosen stall; status completes after zero_polls zero reads.
    initial begin
        int stall_left;
        bit active;
        int polls_seen;
        stall_left = 0;
        active = 0;
        polls_seen = 0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.avm_readdata = $urandom;
            bus.avm_waitrequest = 1'b0;
            if (reset) begin
                active = 0;
                stall_left = 0;
            end else if (bus.avm_read || bus.avm_write) begin
                if (!active) begin
                    active = 1;
                    if (bus.avm_write && bus.avm_address == 3'd0 && stall_wr_cmd > 0)
                        stall_left = stall_wr_cmd;
                    else
                        stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
                end
                if (stall_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    active = 0;
                    if (bus.avm_write && bus.avm_address == 3'd0) polls_seen = 0;
                    if (bus.avm_read) begin
                        bus.avm_readdata[0] = (polls_seen >= zero_polls);
                        polls_seen++;
                    end
                end
            end
        end
    end

    // Monitor: logs completed transfers, checks request hold during stalls, counts done cycles.
    initial begin
        logic [37:0] prev_req;
        logic [37:0] cur_req;
        bit prev_stall;
        prev_stall = 0;
        prev_req = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
            end else begin
                cur_req = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
                if (prev_stall) check_output("hold_during_wait", cur_req, prev_req);
                prev_stall = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
                prev_req = cur_req;
                if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
                    check_output("cs_on_xfer", bus.avm_chipselect, 1'b1);
                    log_q.push_back({bus.avm_write, bus.avm_address,
                                     bus.avm_write ? bus.avm_writedata : 32'h0});
                    log_cyc.push_back(cyc);
                end
                if (bus.done === 1'b1) done_count++;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check_output({tag, "_ready"}, bus.cmd_ready, 1'b1);
        check_output({tag, "_done"}, bus.done, 1'b0);
        check_output({tag, "_err"}, bus.timeout_err, 1'b0);
        check_output({tag, "_bufsel"}, bus.buf_sel, 1'b0);
        check_output({tag, "_strobes"}, {bus.avm_chipselect, bus.avm_write, bus.avm_read}, 3'b000);
        check_output({tag, "_addr"}, bus.avm_address, 3'd0);
        check_output({tag, "_wdata"}, bus.avm_writedata, 32'h0);
    endtask

    task automatic apply_stimulus(input logic [31:0] data, input int zp, input int stall, input bit chk_lat);
        int hs_cyc, done_cyc, dc0, waited, nrd, prev_rd;
        bit exp_to, ready_low;
        zero_polls = zp;
        max_stall = stall;
        log_q.delete();
        log_cyc.delete();
        exp_q.delete();
        exp_to = (TIMEOUT_POLLS != 0) && (zp >= TIMEOUT_POLLS);
        nrd = exp_to ? TIMEOUT_POLLS : zp + 1;
        exp_q.push_back({1'b1, 3'd0, data});
        for (int i = 0; i < nrd; i++) exp_q.push_back({1'b0, 3'd1, 32'h0});
        if (SWAP == 1 && !exp_to) begin
            exp_q.push_back({1'b1, 3'd2, {31'h0, ~model_buf}});
            model_buf = ~model_buf;
        end

        @(negedge clk);
        check_output("ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = data;
        hs_cyc = cyc;
        dc0 = done_count;
        @(negedge clk);
        check_output("err_cleared", bus.timeout_err, 1'b0);
        ready_low = 1;
        waited = 0;
        done_cyc = -1;
        while (done_cyc < 0 && waited < 3000) begin
            if (bus.cmd_ready !== 1'b0) ready_low = 0;
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                bus.cmd_valid = 1'($urandom_range(1, 0));
                bus.cmd_data = $urandom;
                @(negedge clk);
                waited++;
            end
        end
        bus.cmd_valid = 1'b0;
        check_output("done_seen", done_cyc >= 0, 1'b1);
        check_output("ready_low_busy", ready_low, 1'b1);
        check_output("err_at_done", bus.timeout_err, exp_to);
        if (chk_lat) check_output("latency", done_cyc - hs_cyc, 3 + SWAP);
        @(negedge clk);
        check_output("done_one_cycle", bus.done, 1'b0);
        check_output("ready_after", bus.cmd_ready, 1'b1);
        check_output("err_held", bus.timeout_err, exp_to);
        check_output("done_count", done_count - dc0, 1);
        check_output("buf_sel", bus.buf_sel, model_buf);
        check_output("xfer_count", log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            check_output($sformatf("xfer%0d", i), log_q[i], exp_q[i]);
        if (stall == 0) begin
            prev_rd = -1;
            for (int i = 0; i < log_q.size(); i++) begin
                if (!log_q[i].wr && log_q[i].addr == 3'd1) begin
                    if (prev_rd >= 0) check_output("poll_gap", log_cyc[i] - prev_rd, POLL_GAP + 1);
                    prev_rd = log_cyc[i];
                end
            end
        end
    endtask

    task automatic reset_mid(input string tag);
        int dc0;
        dc0 = done_count;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check_reset_vals(tag);
        reset = 1'b0;
        model_buf = 1'b0;
        @(negedge clk);
        check_output({tag, "_no_done"}, done_count - dc0, 0);
        check_output({tag, "_ready_after"}, bus.cmd_ready, 1'b1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        apply_stimulus(32'hDEADBEEF, 0, 0, 1);
        apply_stimulus(32'h12345678, 3, 0, 0);
        stall_wr_cmd = 5;
        apply_stimulus(32'hCAFEF00D, 0, 0, 0);
        stall_wr_cmd = 0;
        apply_stimulus(32'h0BADC0DE, 1000, 0, 0);
        apply_stimulus(32'hA5A5A5A5, 0, 0, 1);

        for (int i = 0; i < 10; i++)
            apply_stimulus($urandom, int'($urandom_range(10, 0)), int'($urandom_range(3, 0)), 0);

        // Reset while idling in the gap between polls.
        zero_polls = 1000;
        max_stall = 0;
        log_q.delete();
        log_cyc.delete();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = 32'h11112222;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (log_q.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("gap_reached", log_q.size() >= 2, 1'b1);
        @(negedge clk);
        check_output("gap_bus_idle", {bus.avm_write, bus.avm_read}, 2'b00);
        reset_mid("rst_gap");

        // Reset while the command write is stalled.
        stall_wr_cmd = 50;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = 32'h33334444;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("stalled_write", {bus.avm_write, bus.avm_address}, {1'b1, 3'd0});
        reset_mid("rst_wr");
        stall_wr_cmd = 0;

        apply_stimulus(32'h55AA55AA, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
